// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// Module      : riscv_pkg
// Description : Shared RV32 constants for the pipeline stages.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
//------------------------------------------------------------------------------
// Module      : if_id_reg
// Description : IF/ID pipeline register with flush > stall > load priority.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
   import riscv_pkg::*;
#(
   parameter int                   ADDRESS_WIDTH = 32,
   parameter int                   DATA_WIDTH    = 32,
   parameter logic [DATA_WIDTH-1:0] NOP          = riscv_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     stall_i,
   input  logic [DATA_WIDTH-1:0]    instr_i,
   input  logic [ADDRESS_WIDTH-1:0] pc_i,
   output logic [DATA_WIDTH-1:0]    instr_o,
   output logic [ADDRESS_WIDTH-1:0] pc_o,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
   output logic                     valid_o,
   output logic                     misaligned_o
);

   logic [DATA_WIDTH-1:0]    instr_q;
   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
   logic                     valid_q;
   logic                     misaligned_q;

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         instr_q      <= NOP;
         pc_q         <= '0;
         pc_plus4_q   <= '0;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
      end else if (!stall_i) begin
         instr_q      <= instr_i;
         pc_q         <= pc_i;
         pc_plus4_q   <= pc_i + ADDRESS_WIDTH'(4);
         valid_q      <= 1'b1;
         misaligned_q <= (pc_i[1:0] != 2'b00);
      end
   end

   assign instr_o      = instr_q;
   assign pc_o         = pc_q;
   assign pc_plus4_o   = pc_plus4_q;
   assign valid_o      = valid_q;
   assign misaligned_o = misaligned_q;

endmodule : if_id_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : fetch_stage
// Description : Program counter, imem address drive and IF/ID capture.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
   import riscv_pkg::*;
#(
   parameter int                      ADDRESS_WIDTH = 32,
   parameter int                      DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = riscv_pkg::RESET_PC,
   parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0]    imem_instr_i,
   input  logic                     stall_f_i,
   input  logic                     flush_d_i,
   input  logic                     pc_src_e_i,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e_i,
   output logic [DATA_WIDTH-1:0]    instr_d_o,
   output logic [ADDRESS_WIDTH-1:0] pc_d_o,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_d_o,
   output logic                     valid_d_o,
   output logic                     misaligned_d_o
);

   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [ADDRESS_WIDTH-1:0] pc_d;

   // Redirect beats stall; the squashed younger fetch is cleared by flush.
   always_comb begin
      pc_d = pc_q + ADDRESS_WIDTH'(4);
      if (pc_src_e_i) begin
         pc_d = pc_target_e_i;
      end else if (stall_f_i) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign imem_addr_o = pc_q;

   if_id_reg #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .NOP           (NOP_INSTR)
   ) u_if_id_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_d_i),
      .stall_i      (stall_f_i),
      .instr_i      (imem_instr_i),
      .pc_i         (pc_q),
      .instr_o      (instr_d_o),
      .pc_o         (pc_d_o),
      .pc_plus4_o   (pc_plus4_d_o),
      .valid_o      (valid_d_o),
      .misaligned_o (misaligned_d_o)
   );

endmodule : fetch_stage

`default_nettype wire
